// File: rtl/draw_tile_param.sv
// Tile ROM to VGA pixel-write copier: one pixel per cycle, optional X/Y mirroring, screen-edge clipping.
// Optional colour-key transparency is enabled by defining DRAW_TILE_PARAM_TRANSPARENT_EN.
module draw_tile_param #(
  parameter int TILE_W      = 8,
  parameter int TILE_H      = 8,
  parameter int TILE_BITS   = 4,
  parameter int COLOR_W     = 9,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = TILE_BITS + $clog2(TILE_W * TILE_H)
`ifdef DRAW_TILE_PARAM_TRANSPARENT_EN
  ,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = COLOR_W'(9'h1FF)
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [X_W-1:0]       Xin,
  input  logic [Y_W-1:0]       Yin,
  input  logic [TILE_BITS-1:0] TileSel,
  input  logic                 FlipX,
  input  logic                 FlipY,
  input  logic [COLOR_W-1:0]   DataIn,
  output logic [ADDR_W-1:0]    Address,
  output logic [X_W-1:0]       X,
  output logic [Y_W-1:0]       Y,
  output logic [COLOR_W-1:0]   Color,
  output logic                 VGA_Draw,
  output logic                 Ready,
  output logic                 Done
);

  localparam int CW = $clog2(TILE_W);
  localparam int RW = $clog2(TILE_H);
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col_nxt;
  logic [RW-1:0]        row_nxt;
  logic [1:0]           drain_cnt;
  logic                 last_px;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [TILE_BITS-1:0] tile_q;
  logic                 fx_q;
  logic                 fy_q;

  // Tile dimensions are powers of two, so mirroring is a bitwise invert and
  // the linear ROM address is a plain concatenation.
  function automatic logic [ADDR_W-1:0] rom_addr(input logic [TILE_BITS-1:0] tile,
                                                 input logic fx, input logic fy,
                                                 input logic [CW-1:0] c,
                                                 input logic [RW-1:0] r);
    logic [CW-1:0] cm;
    logic [RW-1:0] rm;
    cm = fx ? ~c : c;
    rm = fy ? ~r : r;
    return {tile, rm, cm};
  endfunction

  function automatic logic in_bounds(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (int'(sx) < SCREEN_W) && (int'(sy) < SCREEN_H);
  endfunction

  assign last_px = (col == COL_LAST) && (row == ROW_LAST);

  always_comb begin
    col_nxt = col + CW'(1);
    row_nxt = (col == COL_LAST) ? row + RW'(1) : row;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
      Address   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Enable) begin
            state   <= S_FETCH;
            col     <= '0;
            row     <= '0;
            Address <= rom_addr(TileSel, FlipX, FlipY, '0, '0);
          end
        end
        S_FETCH: begin
          if (last_px) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            state     <= (MEM_LATENCY > 0) ? S_DRAIN : S_IDLE;
          end else begin
            col     <= col_nxt;
            row     <= row_nxt;
            Address <= rom_addr(tile_q, fx_q, fy_q, col_nxt, row_nxt);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'(MEM_LATENCY - 1)) state <= S_IDLE;
          else drain_cnt <= drain_cnt + 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (state == S_IDLE && Enable) begin
      x_q    <= Xin;
      y_q    <= Yin;
      tile_q <= TileSel;
      fx_q   <= FlipX;
      fy_q   <= FlipY;
    end
  end

  // Stage p0: screen position of the address issued this cycle
  logic [X_W:0]   sum_x_p0;
  logic [Y_W:0]   sum_y_p0;
  logic           vld_p0;
  logic           last_p0;
  logic           vis_p0;

  always_comb begin
    sum_x_p0 = {1'b0, x_q} + (X_W+1)'(col);
    sum_y_p0 = {1'b0, y_q} + (Y_W+1)'(row);
    vld_p0   = (state == S_FETCH);
    last_p0  = vld_p0 && last_px;
    vis_p0   = in_bounds(sum_x_p0, sum_y_p0);
  end

  logic           vld_o;
  logic           last_o;
  logic           vis_o;
  logic [X_W-1:0] x_o;
  logic [Y_W-1:0] y_o;

  generate
    if (MEM_LATENCY == 0) begin : g_nodly
      assign vld_o  = vld_p0;
      assign last_o = last_p0;
      assign vis_o  = vis_p0;
      assign x_o    = sum_x_p0[X_W-1:0];
      assign y_o    = sum_y_p0[Y_W-1:0];
    end else begin : g_dly
      logic [MEM_LATENCY:1] vld_p;
      logic [MEM_LATENCY:1] last_p;
      logic [MEM_LATENCY:1] vis_p;
      logic [X_W-1:0]       x_p [1:MEM_LATENCY];
      logic [Y_W-1:0]       y_p [1:MEM_LATENCY];

      // Stages p1..pN: position delayed to line up with the ROM read data
      always_ff @(posedge Clock) begin
        if (Reset) begin
          vld_p  <= '0;
          last_p <= '0;
        end else begin
          vld_p[1]  <= vld_p0;
          last_p[1] <= last_p0;
          for (int i = 2; i <= MEM_LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
          end
        end
      end

      always_ff @(posedge Clock) begin
        vis_p[1] <= vis_p0;
        x_p[1]   <= sum_x_p0[X_W-1:0];
        y_p[1]   <= sum_y_p0[Y_W-1:0];
        for (int i = 2; i <= MEM_LATENCY; i++) begin
          vis_p[i] <= vis_p[i-1];
          x_p[i]   <= x_p[i-1];
          y_p[i]   <= y_p[i-1];
        end
      end

      assign vld_o  = vld_p[MEM_LATENCY];
      assign last_o = last_p[MEM_LATENCY];
      assign vis_o  = vis_p[MEM_LATENCY];
      assign x_o    = x_p[MEM_LATENCY];
      assign y_o    = y_p[MEM_LATENCY];
    end
  endgenerate

  logic opaque;
`ifdef DRAW_TILE_PARAM_TRANSPARENT_EN
  assign opaque = (DataIn != TRANSPARENT_COLOR);
`else
  assign opaque = 1'b1;
`endif

  // Output stage: coordinates forced to zero when no pixel is in flight
  assign Color    = DataIn;
  assign VGA_Draw = vld_o && vis_o && opaque;
  assign X        = vld_o ? x_o : '0;
  assign Y        = vld_o ? y_o : '0;
  assign Done     = last_o;
  assign Ready    = (state == S_IDLE);

endmodule
